counter_share_ctrl: RTL

Round-robin controller that shares one N-bit counter datapath among REQ requesters. Each requester asks for a count run with its own target and mode: linear increment, or doubling (shift-left from 1). The controller grants the counter to one requester at a time, seeds it, steps it until the target is reached or the doubling run overflows, then reports completion and moves to the next requester. It sits between the lab's requester blocks and the shared counter register, which it drives directly.

---
 rtl/counter_share_ctrl_if.sv | 27 ++
 rtl/counter_share_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/counter_share_ctrl_if.sv
// Bundle of requester-side and counter-side signals for the shared counter
// controller. The master modport is the requester/lab side; the slave
// modport is the controller itself.
interface counter_share_ctrl_if #(
    parameter int N   = 5,
    parameter int REQ = 4
);
    logic [REQ-1:0]   req;
    logic [REQ*N-1:0] req_target;
    logic [REQ-1:0]   req_mode;
    logic [REQ-1:0]   grant;
    logic             busy;
    logic [N-1:0]     cnt_value;
    logic             cnt_enable;
    logic [REQ-1:0]   done;
    logic             err;

    modport master (
        output req, req_target, req_mode,
        input  grant, busy, cnt_value, cnt_enable, done, err
    );

    modport slave (
        input  req, req_target, req_mode,
        output grant, busy, cnt_value, cnt_enable, done, err
    );
endinterface

// File: rtl/counter_share_ctrl.sv
// Round-robin owner of one shared N-bit counter. Each granted requester gets
// a single run (increment or doubling) up to its latched target, then a
// one-cycle done pulse with err flagging a doubling run that ran off the top.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among req starting at the rr pointer
// LOAD  | owner granted; seed counter (0 increment, 1 doubling)
// RUN   | compare counter to target, otherwise step it
// DONE  | pulse done to owner, drive err, advance pointer past owner
module counter_share_ctrl #(
    parameter int N   = 5,
    parameter int REQ = 4
) (
    input logic                 clk,
    input logic                 reset,
    counter_share_ctrl_if.slave bus
);
    localparam int IW = (REQ > 1) ? $clog2(REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  owner, owner_nxt;
    logic [IW-1:0]  ptr, ptr_nxt;
    logic [N-1:0]   target, target_nxt;
    logic           mode, mode_nxt;
    logic [N-1:0]   cnt, cnt_nxt;
    logic           err_q, err_nxt;

    logic [REQ-1:0] owner_1hot;
    logic [IW-1:0]  owner_inc;
    logic           owner_req;

    logic           hit_hi, hit_any;
    logic [IW-1:0]  pick_hi, pick_any, pick;
    logic [N-1:0]   pick_target;
    logic           pick_mode;

    assign owner_1hot = REQ'(1) << owner;
    assign owner_inc  = (owner == IW'(REQ - 1)) ? '0 : owner + 1'b1;
    assign owner_req  = |(bus.req & owner_1hot);

    // Round-robin pick: lowest set req at or above the pointer wins, else
    // the lowest set req overall (the wrap-around case).
    always_comb begin
        hit_hi      = 1'b0;
        hit_any     = 1'b0;
        pick_hi     = '0;
        pick_any    = '0;
        pick_target = '0;
        pick_mode   = 1'b0;
        for (int i = REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                hit_any  = 1'b1;
                pick_any = IW'(i);
                if (IW'(i) >= ptr) begin
                    hit_hi  = 1'b1;
                    pick_hi = IW'(i);
                end
            end
        end
        pick = hit_hi ? pick_hi : pick_any;
        for (int i = 0; i < REQ; i++) begin
            if (IW'(i) == pick) begin
                pick_target = bus.req_target[i*N +: N];
                pick_mode   = bus.req_mode[i];
            end
        end
    end

    // State and datapath registers; synchronous reset to the idle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            ptr    <= '0;
            target <= '0;
            mode   <= 1'b0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            ptr    <= ptr_nxt;
            target <= target_nxt;
            mode   <= mode_nxt;
            cnt    <= cnt_nxt;
            err_q  <= err_nxt;
        end
    end

    // Next-state, datapath update and output decode. A dropped owner request
    // takes priority over the compare so an abort never steps the counter.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        ptr_nxt        = ptr;
        target_nxt     = target;
        mode_nxt       = mode;
        cnt_nxt        = cnt;
        err_nxt        = err_q;
        bus.grant      = '0;
        bus.busy       = 1'b0;
        bus.cnt_enable = 1'b0;
        bus.done       = '0;
        bus.err        = 1'b0;
        case (state)
            IDLE: begin
                if (hit_any) begin
                    owner_nxt  = pick;
                    target_nxt = pick_target;
                    mode_nxt   = pick_mode;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                bus.grant = owner_1hot;
                bus.busy  = 1'b1;
                if (!owner_req) begin
                    ptr_nxt   = owner_inc;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = mode ? N'(1) : '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.grant = owner_1hot;
                bus.busy  = 1'b1;
                if (!owner_req) begin
                    ptr_nxt   = owner_inc;
                    state_nxt = IDLE;
                end else if (cnt == target) begin
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (!mode) begin
                    cnt_nxt        = cnt + 1'b1;
                    bus.cnt_enable = 1'b1;
                end else if (cnt[N-1]) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt        = {cnt[N-2:0], 1'b0};
                    bus.cnt_enable = 1'b1;
                end
            end
            DONE: begin
                bus.grant = owner_1hot;
                bus.busy  = 1'b1;
                bus.done  = owner_1hot;
                bus.err   = err_q;
                ptr_nxt   = owner_inc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cnt_value = cnt;
endmodule
